// File: rtl/systolic_setup.sv
// Input skew stage for the systolic MAC array.
// Lane i is delayed by i+1 cycles; tracks batch end and drain.
module systolic_setup #(
   parameter int ROW_NUMBER = 256
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [0:ROW_NUMBER-1][7:0]    in_data,
   input  logic                          in_last,
   output logic [0:ROW_NUMBER-1][7:0]    left_out,
   output logic [ROW_NUMBER-1:0]         lane_valid,
   output logic                          busy,
   output logic                          done
);

   localparam int CW = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(ROW_NUMBER - 2);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } state_t;

   state_t        state;
   logic [CW-1:0] drain_cnt;
   logic          accept;

   assign in_ready = !reset && (state != DRAIN);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   for (genvar i = 0; i < ROW_NUMBER; i++) begin : g_lane
      logic [7:0] dat [0:i];
      logic       vld [0:i];

      // Free-running shift line; bubbles enter as zero data.
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int j = 0; j <= i; j++) begin
               dat[j] <= 8'h00;
               vld[j] <= 1'b0;
            end
         end else begin
            dat[0] <= accept ? in_data[i] : 8'h00;
            vld[0] <= accept;
            for (int j = 1; j <= i; j++) begin
               dat[j] <= dat[j-1];
               vld[j] <= vld[j-1];
            end
         end
      end

      assign left_out[i]   = dat[i];
      assign lane_valid[i] = vld[i];
   end

   // Batch tracking: stream until last, then drain the skew.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         drain_cnt <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE, STREAM: begin
               if (accept) begin
                  state     <= in_last ? DRAIN : STREAM;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (drain_cnt == LAST_CNT) begin
                  state     <= IDLE;
                  drain_cnt <= '0;
                  done      <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               drain_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_setup.sv
// Scoreboard bench for systolic_setup: random and directed
// batches checked against a cycle-scheduled reference model.
module tb_systolic_setup;

   localparam int R = 4;
   typedef logic [0:R-1][7:0] vec_t;
   typedef struct {
      int         t;
      logic [7:0] d;
   } ent_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   vec_t         in_data = '0;
   logic         in_ready;
   vec_t         left_out;
   logic [R-1:0] lane_valid;
   logic         busy;
   logic         done;

   systolic_setup #(.ROW_NUMBER(R)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .left_out  (left_out),
      .lane_valid(lane_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   ent_t lq [R][$];
   int   done_q [$];
   int   first_t = -1;
   int   last_t  = -1;

   task automatic chk(input string nm, input int idx,
                      input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h",
                  nm, idx, cyc, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs against the schedule, then
   // record this cycle's accepted vector into the schedule.
   always @(negedge clk) begin
      logic er;
      logic eb;
      ent_t e;
      if (cyc > 0) begin
         if (last_t >= 0 && cyc >= last_t + R) begin
            first_t = -1;
            last_t  = -1;
         end
         er = !reset && !(last_t >= 0 && cyc > last_t);
         eb = (first_t >= 0) && (cyc > first_t);
         chk("in_ready", 0, int'(in_ready), int'(er));
         chk("busy", 0, int'(busy), int'(eb));
         for (int i = 0; i < R; i++) begin
            if (lq[i].size() > 0 && lq[i][0].t == cyc) begin
               e = lq[i].pop_front();
               chk("lane_valid", i, int'(lane_valid[i]), 1);
               chk("left_out", i, int'(left_out[i]), int'(e.d));
            end else begin
               chk("lane_valid", i, int'(lane_valid[i]), 0);
               chk("left_out", i, int'(left_out[i]), 0);
            end
         end
         if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
            chk("done", 0, int'(done), 1);
         end else begin
            chk("done", 0, int'(done), 0);
         end
         if (reset) begin
            for (int i = 0; i < R; i++) lq[i].delete();
            done_q.delete();
            first_t = -1;
            last_t  = -1;
         end else if (in_valid && er) begin
            for (int i = 0; i < R; i++) begin
               e.t = cyc + 1 + i;
               e.d = in_data[i];
               lq[i].push_back(e);
            end
            if (first_t < 0) first_t = cyc;
            if (in_last) begin
               last_t = cyc;
               done_q.push_back(cyc + R);
            end
         end
      end
   end

   task automatic step(input logic v, input logic l,
                       input logic r, input vec_t d);
      in_valid = v;
      in_last  = l;
      reset    = r;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      vec_t d;
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b0, 1'b0, 1'b1, '0);
      idle(2);
      // single vector batch
      step(1'b1, 1'b1, 1'b0, {8'd1, 8'd2, 8'd3, 8'd4});
      idle(R + 2);
      // back-to-back
      step(1'b1, 1'b0, 1'b0, {8'd1, 8'd1, 8'd1, 8'd1});
      step(1'b1, 1'b1, 1'b0, {8'd2, 8'd2, 8'd2, 8'd2});
      idle(R + 2);
      // gap cycle
      step(1'b1, 1'b0, 1'b0, {8'd5, 8'd6, 8'd7, 8'd8});
      idle(1);
      step(1'b1, 1'b1, 1'b0, {8'd9, 8'd10, 8'd11, 8'd12});
      idle(R + 2);
      // in_last without in_valid is ignored
      step(1'b1, 1'b0, 1'b0, {8'h11, 8'h22, 8'h33, 8'h44});
      step(1'b0, 1'b1, 1'b0, {8'hff, 8'hff, 8'hff, 8'hff});
      step(1'b1, 1'b1, 1'b0, {8'h55, 8'h66, 8'h77, 8'h88});
      idle(R + 2);
      // reset mid-drain discards the batch
      step(1'b1, 1'b1, 1'b0, {8'd1, 8'd2, 8'd3, 8'd4});
      idle(1);
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 1'b0, {8'd1, 8'd2, 8'd3, 8'd4});
      idle(R + 2);
      // random traffic
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < R; i++) d[i] = 8'($urandom);
         step($urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 2,
              $urandom_range(0, 99) < 2, d);
      end
      idle(2 * R + 2);
      for (int i = 0; i < R; i++)
         chk("leftover_lane", i, lq[i].size(), 0);
      chk("leftover_done", 0, done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/systolic_setup.md
Name: systolic_setup

Overview:
- Input-skew stage that sits directly upstream of the systolic MAC array and drives its per-row left inputs.
- Accepts one activation vector (ROW_NUMBER bytes) per cycle over a valid/ready handshake.
- Delays lane i by i extra cycles, producing the diagonal wavefront the array requires.
- Tracks batch end and drains the skew pipeline, then signals completion.

Parameters:
- ROW_NUMBER, 256, number of array rows / input lanes; legal range >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_last valid this cycle
- in_ready  output  1  block can accept a vector this cycle
- in_data  input  8 x [0:ROW_NUMBER-1]  activation vector, element i goes to row i
- in_last  input  1  qualifies the final vector of a batch; ignored unless in_valid
- left_out  output  8 x [0:ROW_NUMBER-1]  skewed bytes to array left inputs
- lane_valid  output  ROW_NUMBER  bit i high when left_out[i] carries accepted data (not a bubble)
- busy  output  1  high from first accept of a batch until done
- done  output  1  one-cycle pulse when the last lane of the last vector is on left_out

Behaviour:
- Accept condition: accept = in_valid && in_ready.
- Delay lines:
  - Lane i is a free-running shift line of i+1 registers (data 8b + valid 1b).
  - The lines shift every cycle; there is no stall, because the array is free-running.
- Lane input per cycle:
  - On accept: {in_data[i], 1}.
  - Otherwise: {8'h00, 0}. A bubble is zero data, so zero contributes nothing to MACs.
- Latency: a vector accepted at cycle t appears on left_out[i] / lane_valid[i] in cycle t+1+i.
  - Lane 0 is 1 cycle.
  - Lane ROW_NUMBER-1 is ROW_NUMBER cycles.
- left_out and lane_valid are the register outputs; there is no combinational path from in_data.
- FSM states IDLE, STREAM, DRAIN.
  - IDLE: in_ready=1, busy=0.
    - accept && !in_last -> STREAM.
    - accept && in_last -> DRAIN (single-vector batch).
  - STREAM: in_ready=1, busy=1.
    - accept && in_last -> DRAIN.
    - A gap cycle (in_valid=0) injects a bubble and stays in STREAM.
  - DRAIN: in_ready=0, busy=1.
    - Counter drain_cnt (clog2(ROW_NUMBER) bits) loads 0 on entry and increments each DRAIN cycle.
    - drain_cnt==ROW_NUMBER-2 -> IDLE, and done is asserted the following cycle.
- Drain timing: with the last vector accepted at t, DRAIN occupies cycles t+1..t+ROW_NUMBER-1.
- Done timing: done=1 and busy=0 in cycle t+ROW_NUMBER, coincident with lane_valid[ROW_NUMBER-1]=1 for that vector.
  - in_ready=1 in that same cycle, so a new batch may be accepted; it does not collide with the drained data.
- done is registered and is high for exactly one cycle per batch.
- in_ready depends only on state (plus reset). It is not a function of in_valid.
- in_last with in_valid=0: ignored, no state change.
- Reset (any state, including mid-DRAIN):
  - All delay-line data -> 0 and valid -> 0.
  - State -> IDLE, drain_cnt -> 0.
  - done=0, busy=0.
  - in_ready=0 during the reset cycle and 1 the cycle after.
  - Vectors in flight are discarded with no done pulse.
- Reset values of outputs: left_out all 0, lane_valid all 0, done 0, busy 0.

Test Plan (ROW_NUMBER=4 unless noted):
- Single vector {1,2,3,4} with in_last at t=0 -> left_out[0]=1@t1, [1]=2@t2, [2]=3@t3, [3]=4@t4; done=1 only @t4; in_ready=0 t1..t3, 1 @t4.
- Back-to-back A={1,1,1,1}, B={2,2,2,2}(last) at t0,t1 -> left_out[3]=1@t4, 2@t5; done@t5; lane_valid[3] high t4..t5 only.
- Gap: A@t0, idle t1, B(last)@t2 -> lane_valid[0] pattern 1,0,1 over t1..t3 with left_out[0]=0 @t2; done@t6.
- in_last with in_valid=0 in STREAM -> stays STREAM, in_ready=1, no done; a later valid+last terminates normally.
- Reset asserted at t2 of a single-vector batch -> t3 all outputs 0, lane_valid 0, no done ever; in_ready=1 @t3 and a new batch behaves as scenario 1.
- ROW_NUMBER=2, vector {9,7} last @t0 -> left_out[0]=9@t1, left_out[1]=7@t2, done@t2, in_ready=0 only @t1.
